// File: rtl/control_unit.sv
// Hardwired multi-cycle control sequencer: fetch (T0-T2), decode (T3), execute/writeback (T4-T6), HALT.
// Outputs are a Moore decode of the state register and IR. A state change takes one clock.
// Memory backpressure: T1 holds Read/MDRin until mem_ready. Optional mul/div path is gated by CU_MULDIV_EN.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        HIin,
  output logic        LOin,
  output logic        Read,
  output logic        Rout_en,
  output logic [3:0]  Rout_sel,
  output logic        Rin_en,
  output logic [3:0]  Rin_sel,
  output logic [4:0]  opcode,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
`ifdef CU_MULDIV_EN
    S_T6   = 4'd7,
`endif
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_ALU_LO = 5'b00011;
  localparam logic [4:0] OP_ALU_HI = 5'b01011;
  localparam logic [4:0] OP_NEG    = 5'b10001;
  localparam logic [4:0] OP_NOT    = 5'b10010;
  localparam logic [4:0] OP_HALT   = 5'b11011;
`ifdef CU_MULDIV_EN
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_DIV    = 5'b01111;
`endif

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic [4:0] ir_op;
  logic [3:0] ra, rb, rc;
  logic       is_binary, is_unary, is_muldiv, is_halt, supported;
  logic       unused_ir;

  assign ir_op     = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  // Low IR bits carry immediates this sequencer never looks at.
  assign unused_ir = ^IR[14:0];

  assign is_binary = (ir_op >= OP_ALU_LO) && (ir_op <= OP_ALU_HI);
  assign is_unary  = (ir_op == OP_NEG) || (ir_op == OP_NOT);
  assign is_halt   = (ir_op == OP_HALT);
`ifdef CU_MULDIV_EN
  assign is_muldiv = (ir_op == OP_MUL) || (ir_op == OP_DIV);
`else
  assign is_muldiv = 1'b0;
`endif
  assign supported = is_binary || is_unary || is_muldiv;

  // Next-state sequencing and sticky illegal-opcode flag.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (mem_ready) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (!supported) begin
          illegal_d = 1'b1;
          state_d   = run ? S_T0 : S_IDLE;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4:    state_d = S_T5;
      S_T5: begin
`ifdef CU_MULDIV_EN
        if (is_muldiv) state_d = S_T6;
        else           state_d = run ? S_T0 : S_IDLE;
`else
        state_d = run ? S_T0 : S_IDLE;
`endif
      end
`ifdef CU_MULDIV_EN
      S_T6:    state_d = run ? S_T0 : S_IDLE;
`endif
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; clear low wins over every other input.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode: each state drives at most one bus source.
  always_comb begin
    PCout    = 1'b0;
    MDRout   = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Read     = 1'b0;
    Rout_en  = 1'b0;
    Rout_sel = 4'd0;
    Rin_en   = 1'b0;
    Rin_sel  = 4'd0;
    opcode   = 5'd0;
    halted   = 1'b0;
    unique case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        PCin  = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        // HALT and unsupported opcodes leave every enable low here.
        if (supported) begin
          Rout_en  = 1'b1;
          Rout_sel = rb;
          Yin      = 1'b1;
        end
      end
      S_T4: begin
        Rout_en  = 1'b1;
        Rout_sel = is_unary ? rb : rc;
        opcode   = ir_op;
        ZLowIn   = 1'b1;
        ZHighIn  = is_muldiv;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin_en  = 1'b1;
          Rin_sel = ra;
        end
      end
`ifdef CU_MULDIV_EN
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
`endif
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;

endmodule
